// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// The error codes are internal only and exist for debug visibility.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_BOTH  = 2'd1;
   localparam logic [1:0] ERR_ALIGN = 2'd2;
   localparam logic [1:0] ERR_RANGE = 2'd3;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with a synchronous write and an enable-gated registered read.
// The contents are never reset.
module mem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port. Accesses are captured
// in IDLE, held for a fixed number of wait states, and completed with a MemReady pulse.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] MemAdd,
   input  logic [31:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] MemReadData,
   output logic        MemReady,
   output logic        MemErr
);

   localparam int AW = clog2(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rd_q, rd_d, wr_q, wr_d;
   logic [1:0]  err_q, err_d;
   logic        zero_q, zero_d;

   logic [29:0] word_off;
   logic [1:0]  err_in;
   logic        enter_resp, ok, ram_we, ram_re;
   logic [31:0] ram_rdata;

   // Base is word aligned, so subtracting word indices equals (MemAdd-BASE_ADDR)>>2.
   // An address below the base wraps to a huge offset and lands in the range check.
   assign word_off = MemAdd[31:2] - BASE_ADDR[31:2];

   always_comb begin
      err_in = ERR_NONE;
      if (MemRead && MemWrite)                 err_in = ERR_BOTH;
      else if (MemAdd[1:0] != 2'b00)           err_in = ERR_ALIGN;
      else if (word_off >= 30'(DEPTH_WORDS))   err_in = ERR_RANGE;
   end

   assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
   assign ok         = (err_q == ERR_NONE);
   assign ram_we     = enter_resp && wr_q && ok;
   assign ram_re     = enter_resp && rd_q && ok;

   // The first WAIT cycle presents the captured index to the RAM; the counter
   // then adds WAIT_STATES further cycles before the response.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      err_d   = err_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: if (MemRead || MemWrite) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
            idx_d   = word_off[AW-1:0];
            wdata_d = WriteData;
            rd_d    = MemRead;
            wr_d    = MemWrite;
            err_d   = err_in;
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Load data is masked to zero after reset and after an erroring load.
      if (enter_resp && rd_q) zero_d = !ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= ERR_NONE;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
      end
   end

   mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign MemReady    = (state_q == RESP);
   assign MemErr      = MemReady && !ok;
   assign MemReadData = zero_q ? 32'd0 : ram_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 0 has WAIT_STATES=0, instance 1 has WAIT_STATES=2.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] add [2];
   logic [31:0] wd  [2];
   logic        rd  [2];
   logic        wr  [2];
   logic [31:0] rdata [2];
   logic        rdy [2];
   logic        err [2];

   int checks = 0;
   int errors = 0;

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .rst_n(rst_n), .MemAdd(add[0]), .WriteData(wd[0]),
      .MemRead(rd[0]), .MemWrite(wr[0]),
      .MemReadData(rdata[0]), .MemReady(rdy[0]), .MemErr(err[0])
   );

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
      .clk(clk), .rst_n(rst_n), .MemAdd(add[1]), .WriteData(wd[1]),
      .MemRead(rd[1]), .MemWrite(wr[1]),
      .MemReadData(rdata[1]), .MemReady(rdy[1]), .MemErr(err[1])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One access on instance s; request dropped and inputs scrambled right after capture.
   task automatic acc(input int s, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_data,
                      input string tag);
      int ws;
      int lat;
      ws = (s == 1) ? 2 : 0;
      @(negedge clk);
      add[s] = a; wd[s] = d; rd[s] = r; wr[s] = w;
      @(posedge clk);
      #1;
      rd[s] = 1'b0; wr[s] = 1'b0; add[s] = 32'h0000_0044; wd[s] = 32'h5555_AAAA;
      lat = -1;
      do begin
         @(negedge clk);
         lat++;
      end while (!rdy[s] && lat < 40);
      chk({tag, " latency"}, 64'(lat), 64'(ws + 1));
      chk({tag, " err"}, 64'(err[s]), 64'(e_err));
      chk({tag, " data"}, 64'(rdata[s]), 64'(e_data));
      @(negedge clk);
      chk({tag, " post"}, 64'({rdy[s], err[s]}), 64'd0);
   endtask

   initial begin
      int lat;
      int gap;
      logic seen;
      for (int i = 0; i < 2; i++) begin
         add[i] = '0; wd[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
      end
      #2;
      chk("reset dut0", 64'({rdata[0], rdy[0], err[0]}), 64'd0);
      chk("reset dut2", 64'({rdata[1], rdy[1], err[1]}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // WAIT_STATES=2
      acc(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, "ws2 wr 0x10");
      acc(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "ws2 rd 0x10");

      // WAIT_STATES=0: last word, just past the end, errors and readback
      acc(0, 1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b0, 32'h0, "ws0 wr 0x3fc");
      acc(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFE_F00D, "ws0 rd 0x3fc");
      acc(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, "ws0 rd 0x400");
      acc(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, "ws0 wr 0x20");
      acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678, "ws0 rd 0x20");
      acc(0, 1'b0, 1'b1, 32'h24, 32'h99, 1'b0, 32'h1234_5678, "ws0 wr keeps data");
      acc(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, "ws0 rd misaligned");
      acc(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h99, "ws0 rd 0x24");
      acc(0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0, "ws0 rd+wr 0x20");
      acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678, "ws0 rd 0x20 again");
      acc(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h7, 1'b1, 32'h1234_5678, "ws0 wr wrap range");

      // Request held through RESP: second capture only after an IDLE gap
      @(negedge clk);
      add[0] = 32'h30; wd[0] = 32'hA5A5_A5A5; wr[0] = 1'b1;
      @(posedge clk);
      #1;
      wd[0] = 32'h5A5A_5A5A;
      lat = -1;
      do begin
         @(negedge clk);
         lat++;
      end while (!rdy[0] && lat < 40);
      chk("hold first latency", 64'(lat), 64'd1);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!rdy[0] && gap < 40);
      wr[0] = 1'b0;
      chk("hold pulse spacing", 64'(gap), 64'd3);
      @(negedge clk);
      acc(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h5A5A_5A5A, "hold rd 0x30");

      // Reset during the WAIT of a write: no response, write never lands
      acc(1, 1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b0, 32'hDEAD_BEEF, "ws2 wr 0x40");
      @(negedge clk);
      add[1] = 32'h40; wd[1] = 32'h7777_7777; wr[1] = 1'b1;
      @(posedge clk);
      #1;
      wr[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst mid-wait outputs", 64'({rdata[1], rdy[1], err[1]}), 64'd0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | rdy[1];
      end
      chk("rst no ready", 64'(seen), 64'd0);
      rst_n = 1'b1;
      acc(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0BAD_F00D, "ws2 rd 0x40 after rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
